// File: rtl/uart_rx_pkg.sv
// Shared types and sizing for the 8N1 UART receiver.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;
    localparam int IDX_W     = 3;

    typedef enum logic [2:0] {
        s_IDLE         = 3'd0,
        s_RX_START_BIT = 3'd1,
        s_RX_DATA_BITS = 3'd2,
        s_RX_STOP_BIT  = 3'd3,
        s_CLEANUP      = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Control and data signals between the UART receiver and its user.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                 i_Enable;
    logic                 i_Rx_Serial;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Rx_Frame_Err;
    logic                 o_Rx_Busy;

    modport master (
        output i_Enable,
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Rx_Frame_Err,
        input  o_Rx_Busy
    );

    modport slave (
        input  i_Enable,
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Frame_Err,
        output o_Rx_Busy
    );

endinterface

// File: rtl/uart_rx_fsm.sv
// Combinational next-state logic of the receiver, plus the half-bit and
// full-bit count decodes the datapath shares with it.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  state_t           current_state,
    input  logic             i_Enable,
    input  logic             rx_s,
    input  logic [CNT_W-1:0] clock_count,
    input  logic [IDX_W-1:0] bit_index,
    output state_t           next_state,
    output logic             half_tick,
    output logic             bit_tick
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    always_comb begin
        half_tick  = (clock_count == HALF_CNT);
        bit_tick   = (clock_count == BIT_CNT);
        next_state = current_state;

        case (current_state)
            s_IDLE: begin
                if (i_Enable && !rx_s) begin
                    next_state = s_RX_START_BIT;
                end
            end
            s_RX_START_BIT: begin
                // A line that is high again at mid-start-bit was only a glitch
                if (half_tick) begin
                    next_state = rx_s ? s_IDLE : s_RX_DATA_BITS;
                end
            end
            s_RX_DATA_BITS: begin
                if (bit_tick && (bit_index == LAST_IDX)) begin
                    next_state = s_RX_STOP_BIT;
                end
            end
            s_RX_STOP_BIT: begin
                if (bit_tick) begin
                    next_state = s_CLEANUP;
                end
            end
            s_CLEANUP: begin
                if (rx_s) begin
                    next_state = s_IDLE;
                end
            end
            default: next_state = s_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling counters, shift
// byte and registered data-valid / framing-error strobes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic     i_Clock,
    input  logic     i_Reset,
    uart_rx_if.slave rx_if
);

    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clock_count_q, clock_count_d;
    logic [IDX_W-1:0]     bit_index_q, bit_index_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 dv_q, dv_d;
    logic                 ferr_q, ferr_d;
    logic                 half_tick;
    logic                 bit_tick;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_rx_fsm #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_fsm (
        .current_state (state_q),
        .i_Enable      (rx_if.i_Enable),
        .rx_s          (rx_s_q),
        .clock_count   (clock_count_q),
        .bit_index     (bit_index_q),
        .next_state    (state_d),
        .half_tick     (half_tick),
        .bit_tick      (bit_tick)
    );

    always_comb begin
        rx_meta_d     = rx_if.i_Rx_Serial;
        rx_s_d        = rx_meta_q;
        clock_count_d = clock_count_q;
        bit_index_d   = bit_index_q;
        shift_d       = shift_q;
        byte_d        = byte_q;
        dv_d          = 1'b0;
        ferr_d        = 1'b0;

        case (state_q)
            s_IDLE: begin
                clock_count_d = '0;
                bit_index_d   = '0;
            end
            s_RX_START_BIT: begin
                clock_count_d = half_tick ? '0 : clock_count_q + CNT_W'(1);
            end
            s_RX_DATA_BITS: begin
                if (bit_tick) begin
                    shift_d[bit_index_q] = rx_s_q;
                    clock_count_d        = '0;
                    bit_index_d          = (bit_index_q < LAST_IDX) ? bit_index_q + IDX_W'(1) : '0;
                end else begin
                    clock_count_d = clock_count_q + CNT_W'(1);
                end
            end
            s_RX_STOP_BIT: begin
                if (bit_tick) begin
                    clock_count_d = '0;
                    // Only a high stop bit lets the assembled byte out
                    if (rx_s_q) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    clock_count_d = clock_count_q + CNT_W'(1);
                end
            end
            s_CLEANUP: begin
                clock_count_d = '0;
            end
            default: begin
                clock_count_d = '0;
                bit_index_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= s_IDLE;
            clock_count_q <= '0;
            bit_index_q   <= '0;
            shift_q       <= '0;
            byte_q        <= '0;
            dv_q          <= 1'b0;
            ferr_q        <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            state_q       <= state_d;
            clock_count_q <= clock_count_d;
            bit_index_q   <= bit_index_d;
            shift_q       <= shift_d;
            byte_q        <= byte_d;
            dv_q          <= dv_d;
            ferr_q        <= ferr_d;
        end
    end

    assign rx_if.o_Rx_DV        = dv_q;
    assign rx_if.o_Rx_Byte      = byte_q;
    assign rx_if.o_Rx_Frame_Err = ferr_q;
    assign rx_if.o_Rx_Busy      = (state_q != s_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed scenario bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    uart_rx_if rx_if ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .rx_if   (rx_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    int         dv_cnt = 0;
    int         ferr_cnt = 0;
    int         busy_cnt = 0;
    int         both_cnt = 0;
    int         dv_cyc [4];
    logic [7:0] dv_byte [4];

    always @(negedge clk) begin
        if (rx_if.o_Rx_DV) begin
            if (dv_cnt < 4) begin
                dv_cyc[dv_cnt]  = cyc;
                dv_byte[dv_cnt] = rx_if.o_Rx_Byte;
            end
            dv_cnt = dv_cnt + 1;
        end
        if (rx_if.o_Rx_Frame_Err) ferr_cnt = ferr_cnt + 1;
        if (rx_if.o_Rx_Busy) busy_cnt = busy_cnt + 1;
        if (rx_if.o_Rx_DV && rx_if.o_Rx_Frame_Err) both_cnt = both_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        dv_cnt   = 0;
        ferr_cnt = 0;
        busy_cnt = 0;
    endtask

    // Drives one frame; drop_en_at = k clears i_Enable at bit slot k (0 = start bit)
    task automatic send_frame(input logic [7:0] d, input logic stop, input int drop_en_at,
                              output int t0);
        t0 = cyc;
        rx_if.i_Rx_Serial = 1'b0;
        if (drop_en_at == 0) rx_if.i_Enable = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_if.i_Rx_Serial = d[i];
            if (drop_en_at == i + 1) rx_if.i_Enable = 1'b0;
            tick(CPB);
        end
        rx_if.i_Rx_Serial = stop;
        tick(CPB);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_if.i_Rx_Serial = 1'b1;
        rx_if.i_Enable = 1'b1;
        tick(3);
        n_tests++; if (rx_if.o_Rx_DV !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b, expected 0", rx_if.o_Rx_DV); end
        n_tests++; if (rx_if.o_Rx_Byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h, expected 00", rx_if.o_Rx_Byte); end
        n_tests++; if (rx_if.o_Rx_Frame_Err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, expected 0", rx_if.o_Rx_Frame_Err); end
        n_tests++; if (rx_if.o_Rx_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", rx_if.o_Rx_Busy); end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_single_byte();
        int t0;
        clear_mon();
        send_frame(8'hA5, 1'b1, -1, t0);
        tick(4);
        n_tests++; if (dv_cnt !== 1) begin n_fail++; $display("FAIL single_dv_count: got %0d, expected 1", dv_cnt); end
        n_tests++; if (dv_byte[0] !== 8'hA5) begin n_fail++; $display("FAIL single_byte_at_dv: got %h, expected a5", dv_byte[0]); end
        n_tests++; if (rx_if.o_Rx_Byte !== 8'hA5) begin n_fail++; $display("FAIL single_byte_held: got %h, expected a5", rx_if.o_Rx_Byte); end
        n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d, expected 0", ferr_cnt); end
        n_tests++; if (dv_cyc[0] - t0 !== 79) begin n_fail++; $display("FAIL single_latency: got %0d, expected 79", dv_cyc[0] - t0); end
        n_tests++; if (rx_if.o_Rx_Busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b, expected 0", rx_if.o_Rx_Busy); end
    endtask

    task automatic test_back_to_back();
        int t0;
        clear_mon();
        send_frame(8'h00, 1'b1, -1, t0);
        send_frame(8'hFF, 1'b1, -1, t0);
        tick(4);
        n_tests++; if (dv_cnt !== 2) begin n_fail++; $display("FAIL b2b_dv_count: got %0d, expected 2", dv_cnt); end
        n_tests++; if (dv_byte[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h, expected 00", dv_byte[0]); end
        n_tests++; if (dv_byte[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h, expected ff", dv_byte[1]); end
        n_tests++; if (dv_cyc[1] - dv_cyc[0] !== 80) begin n_fail++; $display("FAIL b2b_spacing: got %0d, expected 80", dv_cyc[1] - dv_cyc[0]); end
        n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d, expected 0", ferr_cnt); end
    endtask

    task automatic test_false_start();
        clear_mon();
        rx_if.i_Rx_Serial = 1'b0;
        tick(2);
        rx_if.i_Rx_Serial = 1'b1;
        tick(12);
        n_tests++; if (busy_cnt !== 4) begin n_fail++; $display("FAIL false_busy_cycles: got %0d, expected 4", busy_cnt); end
        n_tests++; if (dv_cnt !== 0) begin n_fail++; $display("FAIL false_dv: got %0d, expected 0", dv_cnt); end
        n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL false_ferr: got %0d, expected 0", ferr_cnt); end
        n_tests++; if (rx_if.o_Rx_Busy !== 1'b0) begin n_fail++; $display("FAIL false_idle: got %b, expected 0", rx_if.o_Rx_Busy); end
    endtask

    task automatic test_frame_error();
        int t0;
        clear_mon();
        send_frame(8'h3C, 1'b0, -1, t0);
        tick(200);
        n_tests++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d, expected 1", ferr_cnt); end
        n_tests++; if (dv_cnt !== 0) begin n_fail++; $display("FAIL ferr_dv: got %0d, expected 0", dv_cnt); end
        n_tests++; if (rx_if.o_Rx_Byte !== 8'hFF) begin n_fail++; $display("FAIL ferr_byte_kept: got %h, expected ff", rx_if.o_Rx_Byte); end
        n_tests++; if (rx_if.o_Rx_Busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %b, expected 1", rx_if.o_Rx_Busy); end
        rx_if.i_Rx_Serial = 1'b1;
        tick(5);
        n_tests++; if (rx_if.o_Rx_Busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b, expected 0", rx_if.o_Rx_Busy); end
    endtask

    task automatic test_reset_mid_frame();
        int         t0;
        logic [7:0] partial;
        partial = 8'h33;
        clear_mon();
        rx_if.i_Rx_Serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_if.i_Rx_Serial = partial[i];
            tick(CPB);
        end
        rx_if.i_Rx_Serial = partial[4];
        tick(3);
        #2;
        rst = 1'b1;
        rx_if.i_Rx_Serial = 1'b1;
        #1;
        n_tests++; if (rx_if.o_Rx_Byte !== 8'h00) begin n_fail++; $display("FAIL rstmid_byte: got %h, expected 00", rx_if.o_Rx_Byte); end
        n_tests++; if (rx_if.o_Rx_Busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, expected 0", rx_if.o_Rx_Busy); end
        n_tests++; if (rx_if.o_Rx_DV !== 1'b0) begin n_fail++; $display("FAIL rstmid_dv: got %b, expected 0", rx_if.o_Rx_DV); end
        @(posedge clk);
        #1;
        tick(2);
        rst = 1'b0;
        tick(5);
        clear_mon();
        send_frame(8'h5A, 1'b1, -1, t0);
        tick(4);
        n_tests++; if (dv_cnt !== 1) begin n_fail++; $display("FAIL rstmid_next_dv: got %0d, expected 1", dv_cnt); end
        n_tests++; if (rx_if.o_Rx_Byte !== 8'h5A) begin n_fail++; $display("FAIL rstmid_next_byte: got %h, expected 5a", rx_if.o_Rx_Byte); end
    endtask

    task automatic test_enable();
        int t0;
        clear_mon();
        rx_if.i_Enable = 1'b0;
        send_frame(8'h77, 1'b1, -1, t0);
        tick(4);
        n_tests++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL en_off_busy: got %0d, expected 0", busy_cnt); end
        n_tests++; if (dv_cnt !== 0) begin n_fail++; $display("FAIL en_off_dv: got %0d, expected 0", dv_cnt); end
        rx_if.i_Enable = 1'b1;
        clear_mon();
        send_frame(8'h81, 1'b1, 2, t0);
        tick(4);
        n_tests++; if (dv_cnt !== 1) begin n_fail++; $display("FAIL en_drop_dv: got %0d, expected 1", dv_cnt); end
        n_tests++; if (rx_if.o_Rx_Byte !== 8'h81) begin n_fail++; $display("FAIL en_drop_byte: got %h, expected 81", rx_if.o_Rx_Byte); end
        clear_mon();
        send_frame(8'h42, 1'b1, -1, t0);
        tick(4);
        n_tests++; if (dv_cnt !== 0) begin n_fail++; $display("FAIL en_next_ignored: got %0d, expected 0", dv_cnt); end
        n_tests++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL en_next_busy: got %0d, expected 0", busy_cnt); end
        n_tests++; if (rx_if.o_Rx_Byte !== 8'h81) begin n_fail++; $display("FAIL en_next_byte_kept: got %h, expected 81", rx_if.o_Rx_Byte); end
    endtask

    initial begin
        rx_if.i_Rx_Serial = 1'b1;
        rx_if.i_Enable    = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_reset_mid_frame();
        test_enable();
        n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL dv_and_ferr_overlap: got %0d, expected 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver for 8N1 framing, the receive-side counterpart of the existing UART transmitter FSM in the SPI/UART configuration path. It synchronises the asynchronous serial input and detects the start bit. It samples each bit at its centre using the same `CLKS_PER_BIT` timing as the transmitter, then presents each received byte with a one-cycle valid strobe. Framing errors and line breaks are flagged rather than delivered as data.

## Interface
- `CLKS_PER_BIT`, 5208: system clocks per serial bit (50 MHz / 9600 baud). Legal range 4..65535.
- `i_Clock`  in  1  system clock; all logic on rising edge.
- `i_Reset`  in  1  reset, asynchronous and active-high. Forces every register to its reset value immediately.
- `i_Enable`  in  1  when low, a new start bit is not accepted; a frame already in progress completes.
- `i_Rx_Serial`  in  1  asynchronous serial line, idle high.
- `o_Rx_DV`  out  1  one-cycle pulse; `o_Rx_Byte` is valid from this cycle onward.
- `o_Rx_Byte`  out  8  last correctly framed byte; held until the next good frame.
- `o_Rx_Frame_Err`  out  1  one-cycle pulse when the stop bit samples low.
- `o_Rx_Busy`  out  1  high in every state except `s_IDLE`.

## Operation
- Reset values:
  - All outputs are 0.
  - Both synchroniser flops are 1.
  - State is `s_IDLE`.
  - `clock_count` = 0, `bit_index` = 0, internal shift byte = 0x00.
- A two-flop synchroniser feeds `rx_s`. Every decision below uses `rx_s` only; the raw `i_Rx_Serial` is never used directly.
- `H` = (`CLKS_PER_BIT` − 1) / 2, integer division. `clock_count` is 16 bits and `bit_index` is 3 bits; neither wraps, because the state machine clears them first.
- States and transitions:
  - **`s_IDLE`**
    - `clock_count` and `bit_index` are held at 0.
    - If `i_Enable` && `rx_s` == 0, go to `s_RX_START_BIT`.
  - **`s_RX_START_BIT`**
    - Increment `clock_count` until it equals `H`.
    - At `clock_count` == `H`: if `rx_s` == 0, clear `clock_count` and go to `s_RX_DATA_BITS`.
    - If `rx_s` == 1 at that point, treat it as a false start: go to `s_IDLE` with no pulse on any output.
  - **`s_RX_DATA_BITS`**
    - Increment `clock_count` until it equals `CLKS_PER_BIT` − 1.
    - At that count: shift byte[`bit_index`] ← `rx_s` (LSB first), then clear `clock_count`.
    - If `bit_index` < 7, increment `bit_index` and stay.
    - Otherwise clear `bit_index` and go to `s_RX_STOP_BIT`.
  - **`s_RX_STOP_BIT`**
    - Count to `CLKS_PER_BIT` − 1, then sample `rx_s`.
    - If `rx_s` == 1: `o_Rx_Byte` ← shift byte and `o_Rx_DV` = 1.
    - If `rx_s` == 0: `o_Rx_Frame_Err` = 1 and `o_Rx_Byte` is unchanged.
    - In both cases go to `s_CLEANUP`.
  - **`s_CLEANUP`**
    - `o_Rx_DV` and `o_Rx_Frame_Err` return to 0.
    - Stay while `rx_s` == 0 (break / stuck-low line); go to `s_IDLE` once `rx_s` == 1.
    - After a good frame this state lasts exactly one cycle.
- `o_Rx_DV` and `o_Rx_Frame_Err` are never high in the same cycle.
- Deasserting `i_Enable` is only checked in `s_IDLE`.
- Reset mid-frame discards the partial byte. The next frame after reset is received normally.

## Timing
- Synchroniser latency is 2 cycles from a pin edge to `rx_s`.
- The state machine enters `s_RX_START_BIT` 1 cycle after `rx_s` falls.
- Start-bit check: `H` cycles after entering `s_RX_START_BIT`.
- Data bit n (n = 0..7) is sampled (n+1)·`CLKS_PER_BIT` cycles after the start-bit check.
- The stop bit is sampled 9·`CLKS_PER_BIT` cycles after the start-bit check.
- `o_Rx_DV` / `o_Rx_Frame_Err` are registered and high in the cycle after the stop sample, for exactly 1 cycle.
- `o_Rx_Busy` rises 1 cycle after `rx_s` falls and falls on the cycle `s_IDLE` is re-entered.
- Back-to-back frames (stop bit immediately followed by the next start bit) are received without loss. Cleanup takes 1 cycle, which fits inside the half-bit margin.

## Structure
- The `uart_rx_pkg` package holds:
  - `state_t` enum: `s_IDLE`, `s_RX_START_BIT`, `s_RX_DATA_BITS`, `s_RX_STOP_BIT`, `s_CLEANUP`.
  - Localparams `DATA_BITS` = 8 and `CNT_W` = 16.
- One sub-module, `uart_rx_fsm`: a purely combinational next-state function of `current_state`, `i_Enable`, `rx_s`, `clock_count` and `bit_index`.
- The top level `uart_rx` owns the synchroniser, the state register, the counters, the shift byte and the output registers.

## Test plan
All scenarios use `CLKS_PER_BIT` = 8 (`H` = 3).
- **Single byte:** drive 0xA5 in 8N1 at 8 clocks/bit → exactly one `o_Rx_DV` pulse; `o_Rx_Byte` = 0xA5; `o_Rx_Frame_Err` stays 0.
- **Back-to-back:** 0x00 then 0xFF with no idle gap → two `o_Rx_DV` pulses 80 cycles apart, bytes 0x00 then 0xFF.
- **False start:** 2-cycle low glitch on an idle line → `o_Rx_Busy` pulses briefly; no DV, no error; back in `s_IDLE`.
- **Framing error / break:** 0x3C with stop bit 0, then line held low 200 cycles → one `o_Rx_Frame_Err` pulse, no DV, `o_Rx_Byte` keeps its previous value; `o_Rx_Busy` stays high until the line returns high.
- **Reset mid-frame:** pulse `i_Reset` during data bit 4 → all outputs 0 immediately; the following frame 0x5A is received as 0x5A.
- **Enable gating:**
  - Start bit arrives with `i_Enable` = 0 → ignored.
  - `i_Enable` dropped mid-frame while 0x81 is in flight → 0x81 is still delivered; the next frame is ignored.
